// File: rtl/reset_seq.sv
// reset_seq: sequenced reset generator.
// Releases rst_out bits one at a time, bit 0 first, once every PLL lock flag
// has been stable for LOCK_FILT cycles with no external or software reset.
// When conditions go bad, all outputs re-assert at once. The FSM state is
// exported on 'state' so a checker can follow the sequence.
// All control inputs are levels; this block has no valid/ready handshake.
module reset_seq #(
  parameter int NUM_OUT   = 3,
  parameter int NUM_LOCK  = 1,
  parameter int LOCK_FILT = 8,
  parameter int STAGE_DLY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LOCK-1:0] pll_lock,
  input  logic                ext_reset,
  input  logic                sw_reset,
  output logic [NUM_OUT-1:0]  rst_out,
  output logic                all_done,
  output logic [1:0]          state,
  output logic [7:0]          lock_loss_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // One counter serves both the lock filter and the stage spacing.
  localparam int CNT_MAX = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILT - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DLY - 1);

  logic [NUM_LOCK-1:0] lock_s1, lock_s;
  logic                ext_s1, ext_s;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_OUT-1:0]  rst_q, rst_d;
  logic                done_q, done_d;
  logic [7:0]          loss_q, loss_d;

  logic                lock_ok;
  logic                good;
  logic [NUM_OUT-1:0]  rst_shift;

  // Two-flop synchronisers for the asynchronous lock and external reset inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_s1 <= '0;
      lock_s  <= '0;
      ext_s1  <= 1'b0;
      ext_s   <= 1'b0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s  <= lock_s1;
      ext_s1  <= ext_reset;
      ext_s   <= ext_s1;
    end
  end

  assign lock_ok   = &lock_s;
  assign good      = lock_ok & ~ext_s & ~sw_reset;
  // Releasing the next stage shifts a zero in from the bottom: 111 -> 110 -> 100 -> 000.
  assign rst_shift = rst_q << 1;

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    loss_d  = loss_q;
    case (state_q)
      IDLE: begin
        rst_d  = '1;
        done_d = 1'b0;
        cnt_d  = '0;
        if (good) state_d = FILTER;
      end
      FILTER, RELEASE: begin
        if (!good) begin
          state_d = IDLE;
          rst_d   = '1;
          done_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == FILTER) ? FILT_LAST : STAGE_LAST)) begin
          cnt_d = '0;
          rst_d = rst_shift;
          if (rst_shift == '0) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!good) begin
          state_d = IDLE;
          rst_d   = '1;
          done_d  = 1'b0;
          cnt_d   = '0;
          // Only lock loss is counted; ext/sw resets are deliberate.
          if (!lock_ok && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rst_d   = '1;
        done_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign rst_out       = rst_q;
  assign all_done      = done_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed bench for reset_seq (default build plus a
// NUM_OUT=1 / NUM_LOCK=2 build). Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] pll_lock = 1'b0;
  logic       ext_reset = 1'b0;
  logic       sw_reset = 1'b0;
  logic [2:0] rst_out;
  logic       all_done;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;

  logic [1:0] pll_lock1 = 2'b01;
  logic [0:0] rst_out1;
  logic       all_done1;
  logic [1:0] state1;
  logic [7:0] lock_loss_cnt1;

  int checks = 0;
  int errors = 0;

  reset_seq dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .ext_reset(ext_reset),
    .sw_reset(sw_reset), .rst_out(rst_out), .all_done(all_done),
    .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  reset_seq #(.NUM_OUT(1), .NUM_LOCK(2), .LOCK_FILT(3), .STAGE_DLY(2)) dut1 (
    .clk(clk), .rst(rst), .pll_lock(pll_lock1), .ext_reset(1'b0),
    .sw_reset(1'b0), .rst_out(rst_out1), .all_done(all_done1),
    .state(state1), .lock_loss_cnt(lock_loss_cnt1)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_main(input string tag, input logic [2:0] r, input logic d, input logic [1:0] s);
    chk({tag, ".rst_out"}, 32'(rst_out), 32'(r));
    chk({tag, ".all_done"}, 32'(all_done), 32'(d));
    chk({tag, ".state"}, 32'(state), 32'(s));
  endtask

  initial begin
    int exp_cnt;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk_main("async_rst", 3'b111, 1'b0, 2'd0);
    chk("async_rst.cnt", 32'(lock_loss_cnt), 32'd0);
    edges(3);
    chk_main("rst_held", 3'b111, 1'b0, 2'd0);

    // Release reset; lock first sampled at the next edge T.
    rst = 1'b0;
    pll_lock = 1'b1;
    edges(2);
    chk_main("A.T1_idle", 3'b111, 1'b0, 2'd0);
    edges(1);
    chk_main("A.T2_filter", 3'b111, 1'b0, 2'd1);
    edges(7);
    chk_main("A.T9", 3'b111, 1'b0, 2'd1);
    edges(1);
    chk_main("A.T10", 3'b110, 1'b0, 2'd2);
    edges(3);
    chk_main("A.T13", 3'b110, 1'b0, 2'd2);
    edges(1);
    chk_main("A.T14", 3'b100, 1'b0, 2'd2);
    edges(3);
    chk_main("A.T17", 3'b100, 1'b0, 2'd2);
    edges(1);
    chk_main("A.T18_run", 3'b000, 1'b1, 2'd3);

    // One-cycle lock drop in RUN.
    pll_lock = 1'b0;
    edges(1);
    pll_lock = 1'b1;
    edges(1);
    chk_main("B.E2", 3'b000, 1'b1, 2'd3);
    edges(1);
    chk_main("B.E3_idle", 3'b111, 1'b0, 2'd0);
    chk("B.cnt", 32'(lock_loss_cnt), 32'd1);
    edges(1);
    chk_main("B.E4_filter", 3'b111, 1'b0, 2'd1);
    edges(8);
    chk_main("B.E12", 3'b110, 1'b0, 2'd2);
    edges(4);
    chk_main("B.E16", 3'b100, 1'b0, 2'd2);
    edges(4);
    chk_main("B.E20_run", 3'b000, 1'b1, 2'd3);

    // sw_reset from RUN, then again at FILTER cycle 5.
    sw_reset = 1'b1;
    edges(1);
    sw_reset = 1'b0;
    chk_main("C.sw_run", 3'b111, 1'b0, 2'd0);
    edges(1);
    chk_main("C.filter", 3'b111, 1'b0, 2'd1);
    edges(4);
    sw_reset = 1'b1;
    edges(1);
    sw_reset = 1'b0;
    chk_main("C.sw_filter", 3'b111, 1'b0, 2'd0);
    chk("C.cnt", 32'(lock_loss_cnt), 32'd1);
    edges(1);
    chk_main("C.refilter", 3'b111, 1'b0, 2'd1);
    edges(7);
    chk_main("C.F7", 3'b111, 1'b0, 2'd1);
    edges(1);
    chk_main("C.F8", 3'b110, 1'b0, 2'd2);
    edges(8);
    chk_main("C.run", 3'b000, 1'b1, 2'd3);

    // ext_reset held for 20 cycles in RUN.
    ext_reset = 1'b1;
    edges(2);
    chk_main("D.X2", 3'b000, 1'b1, 2'd3);
    edges(1);
    chk_main("D.X3", 3'b111, 1'b0, 2'd0);
    for (int i = 0; i < 17; i++) begin
      edges(1);
      chk("D.hold", 32'(rst_out), 32'h7);
    end
    ext_reset = 1'b0;
    edges(1);
    chk_main("D.R", 3'b111, 1'b0, 2'd0);
    edges(1);
    chk_main("D.R1", 3'b111, 1'b0, 2'd0);
    edges(1);
    chk_main("D.R2_filter", 3'b111, 1'b0, 2'd1);
    chk("D.cnt", 32'(lock_loss_cnt), 32'd1);
    edges(16);
    chk_main("D.run", 3'b000, 1'b1, 2'd3);

    // Repeated lock drops until the loss counter saturates.
    for (int i = 0; i < 299; i++) begin
      pll_lock = 1'b0;
      edges(1);
      pll_lock = 1'b1;
      edges(19);
      exp_cnt = (i + 2 > 255) ? 255 : i + 2;
      chk("E.state", 32'(state), 32'd3);
      chk("E.cnt", 32'(lock_loss_cnt), 32'(exp_cnt));
    end
    pll_lock = 1'b0;
    edges(1);
    pll_lock = 1'b1;
    edges(2);
    chk_main("E.idle", 3'b111, 1'b0, 2'd0);
    chk("E.sat", 32'(lock_loss_cnt), 32'd255);
    edges(9);
    chk_main("E.rel", 3'b110, 1'b0, 2'd2);
    edges(2);
    // Mid-RELEASE asynchronous reset, sampled before any further edge.
    rst = 1'b1;
    #1;
    chk_main("E.async", 3'b111, 1'b0, 2'd0);
    chk("E.async_cnt", 32'(lock_loss_cnt), 32'd0);
    edges(2);
    chk_main("E.rst_held", 3'b111, 1'b0, 2'd0);
    rst = 1'b0;
    edges(2);
    chk_main("E.T1", 3'b111, 1'b0, 2'd0);
    edges(1);
    chk_main("E.T2", 3'b111, 1'b0, 2'd1);
    edges(8);
    chk_main("E.T10", 3'b110, 1'b0, 2'd2);

    // NUM_OUT=1, NUM_LOCK=2 build: one lock low keeps it idle.
    chk("F.idle_state", 32'(state1), 32'd0);
    chk("F.idle_rst", 32'(rst_out1), 32'd1);
    pll_lock1 = 2'b11;
    edges(3);
    chk("F.T2_state", 32'(state1), 32'd1);
    edges(2);
    chk("F.T4_rst", 32'(rst_out1), 32'd1);
    chk("F.T4_done", 32'(all_done1), 32'd0);
    edges(1);
    chk("F.T5_rst", 32'(rst_out1), 32'd0);
    chk("F.T5_done", 32'(all_done1), 32'd1);
    chk("F.T5_state", 32'(state1), 32'd3);
    pll_lock1 = 2'b10;
    edges(3);
    chk("F.drop_rst", 32'(rst_out1), 32'd1);
    chk("F.drop_done", 32'(all_done1), 32'd0);
    chk("F.drop_cnt", 32'(lock_loss_cnt1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NUM_OUT, default 3: number of sequenced reset outputs (legal range 1..16).
REQ-002 SHALL have parameter NUM_LOCK, default 1: number of PLL lock inputs (legal range 1..4).
REQ-003 SHALL have parameter LOCK_FILT, default 8: consecutive good cycles required before the first release (>=1).
REQ-004 SHALL have parameter STAGE_DLY, default 4: cycles between successive output releases (>=1).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, NUM_LOCK: asynchronous lock flags, all required high.
REQ-008 SHALL have port ext_reset, input, 1: asynchronous active-high external reset request.
REQ-009 SHALL have port sw_reset, input, 1: synchronous one-cycle reset request pulse.
REQ-010 SHALL have port rst_out, output, NUM_OUT: active-high sequenced resets; bit 0 is released first.
REQ-011 SHALL have port all_done, output, 1: high when every rst_out bit is released.
REQ-012 SHALL have port state, output, 2: current FSM state code.
REQ-013 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses while in RUN.

Function
REQ-014 SHALL pass each pll_lock bit and ext_reset through a 2-flop synchroniser (lock_s, ext_s); sw_reset is used unsynchronised.
REQ-015 SHALL define good = (all lock_s bits high) AND ext_s low AND sw_reset low.
REQ-016 SHALL implement FSM states IDLE=0, FILTER=1, RELEASE=2, RUN=3.
REQ-017 IDLE: all rst_out=1; when good, SHALL go to FILTER on the same edge and clear the counter.
REQ-018 FILTER: SHALL count good cycles; the edge completing LOCK_FILT cycles in FILTER SHALL move to RELEASE and clear rst_out[0].
REQ-019 RELEASE: SHALL clear rst_out[k] exactly STAGE_DLY edges after rst_out[k-1]; the edge clearing rst_out[NUM_OUT-1] SHALL enter RUN and set all_done.
REQ-020 NUM_OUT=1: the FILTER-exit edge SHALL clear rst_out[0], enter RUN and set all_done together, skipping RELEASE.
REQ-021 In FILTER, RELEASE or RUN, any cycle with good low SHALL return to IDLE on that edge, set all rst_out=1, clear all_done and clear the counter.
REQ-022 Already-released outputs SHALL re-assert simultaneously; no reverse sequencing.
REQ-023 A return from RUN caused by any lock_s bit low SHALL increment lock_loss_cnt, saturating at 255; ext_s or sw_reset causes SHALL NOT increment it.
REQ-024 A single bad cycle during FILTER SHALL restart filtering from zero after IDLE.
REQ-025 Latency: pll_lock first sampled high at edge T, other conditions good -> FILTER entered at T+2, rst_out[0] low at T+2+LOCK_FILT, rst_out[k] low at T+2+LOCK_FILT+k*STAGE_DLY.
REQ-026 Latency: pll_lock falling before edge T -> rst_out all high after edge T+2; sw_reset high at edge T -> all high after edge T.
REQ-027 All outputs SHALL be registered; rst_out bits SHALL be glitch-free.
REQ-028 The counter SHALL be sized to hold max(LOCK_FILT, STAGE_DLY) and SHALL never wrap.

Reset
REQ-029 rst high SHALL asynchronously force rst_out all ones, all_done=0, state=IDLE, counter=0, lock_loss_cnt=0, and all synchroniser flops=0.
REQ-030 After rst deasserts, the block SHALL behave as REQ-025 from the first edge sampling pll_lock high.
REQ-031 rst_out SHALL remain all ones for the whole time rst is high, independent of clk.

Verification
REQ-032 Defaults, pll_lock rises before edge 0: rst_out 111 until edge 10, 110 at edge 10, 100 at edge 14, 000 with all_done=1 at edge 18.
REQ-033 In RUN, drop pll_lock for 1 cycle: rst_out=111 two edges later, lock_loss_cnt 0->1, full sequence replays with REQ-032 spacing.
REQ-034 sw_reset pulse at FILTER cycle 5: IDLE next edge, lock_loss_cnt unchanged, rst_out[0] released 8 edges after FILTER re-entry.
REQ-035 ext_reset held high 20 cycles in RUN: rst_out=111 throughout, no increment, sequence restarts 2 edges after release.
REQ-036 300 lock drops from RUN: lock_loss_cnt saturates at 255; then assert rst mid-RELEASE: outputs 111, cnt 0 with no clk edge.
REQ-037 NUM_OUT=1, NUM_LOCK=2, one lock low: stays IDLE; both high: rst_out and all_done change on the same edge.
